// File: rtl/i2c_slave_regs.sv
// -----------------------------------------------------------------------------
// i2c_slave_regs
//
// I2C target with a 2^REG_AW x 8 register file. Oversamples scl/SDA on clk,
// detects START/STOP, matches a 7-bit address, loads a register pointer from
// the first written byte, then writes (W) or reads (R) bytes with pointer
// auto-increment and wrap.
//
// Ports
//   clk         system clock; scl and SDA are oversampled on it
//   reset       asynchronous, active-low reset
//   scl         bus clock from the master
//   SDA_in      resolved (wired-AND) bus SDA
//   SDA_out     target SDA drive: 0 pulls low, 1 releases
//   busy        high from an address match until STOP / return to IDLE
//   wr_strobe   one-clk pulse per data byte written to the register file
//   wr_addr     register index of that write (valid with wr_strobe)
//   wr_data     byte written (valid with wr_strobe)
//   dbg_state_o current FSM state (IDLE encodes as 0), for observation only
//
// wr_strobe is a fire-and-forget notification: there is no ready/backpressure,
// a consumer must take wr_addr/wr_data in the single cycle wr_strobe is high.
// -----------------------------------------------------------------------------
module i2c_slave_regs #(
    parameter logic [6:0]  SLAVE_ADDR = 7'b1101001,
    parameter int unsigned REG_AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    input  logic              SDA_in,
    output logic              SDA_out,
    output logic              busy,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [3:0]        dbg_state_o
);

    localparam int NREG = 1 << REG_AW;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

    // -------------------------------------------------------------------------
    // Input conditioning: [0],[1] synchronise, [2] is the edge-detect history.
    // Reset to 1 so an idle (high) bus produces no edge on reset release.
    // -------------------------------------------------------------------------
    logic [2:0] scl_sync_q;
    logic [2:0] sda_sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl};
            sda_sync_q <= {sda_sync_q[1:0], SDA_in};
        end
    end

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & sda_sync_q[2] & ~sda_s;
    assign stop_det  = scl_s & ~sda_sync_q[2] & sda_s;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    // Sub-phase inside ACK states: 0 = waiting for the fall that opens the
    // slot, 1 = slot open (for RDATA_ACK: master ACK seen, waiting for fall).
    logic              ph_q, ph_d;
    logic              sda_out_q, sda_out_d;
    logic              busy_q, busy_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en;

    logic [7:0]        regs_q [NREG];
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;

    // Byte as it stands including the bit being sampled on this rising edge.
    assign rx_byte = {shift_q[6:0], sda_s};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ph_d        = ph_q;
        sda_out_d   = sda_out_q;
        busy_d      = busy_q;
        wr_en       = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // Bus conditions win over any bit activity in the same clk.
        if (stop_det) begin
            state_d   = IDLE;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
            ph_d      = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps ptr and drops any partial byte.
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            sda_out_d = 1'b1;
            ph_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sda_out_d = 1'b1;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                                ph_d    = 1'b0;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ph_q) begin
                            sda_out_d = 1'b0;
                            ph_d      = 1'b1;
                        end else begin
                            ph_d      = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                // First read bit goes out on the fall that
                                // closes the ACK slot.
                                state_d   = RDATA;
                                sda_out_d = rd_byte[7];
                                shift_d   = {rd_byte[6:0], 1'b0};
                            end else begin
                                sda_out_d = 1'b1;
                                state_d   = (state_q == ADDR_ACK) ? REG : WDATA;
                            end
                        end
                    end
                end

                REG: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d   = rx_byte[REG_AW-1:0];
                            state_d = REG_ACK;
                            ph_d    = 1'b0;
                        end
                    end
                end

                WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_en       = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = rx_byte;
                            ptr_d       = ptr_q + REG_AW'(1);
                            state_d     = WDATA_ACK;
                            ph_d        = 1'b0;
                        end
                    end
                end

                RDATA: begin
                    // shift_q[7] always holds the next bit to present.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_out_d = 1'b1;
                            state_d   = RDATA_ACK;
                            ph_d      = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            sda_out_d = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end
                end

                RDATA_ACK: begin
                    if (!ph_q && scl_rise) begin
                        if (sda_s) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            ptr_d = ptr_q + REG_AW'(1);
                            ph_d  = 1'b1;
                        end
                    end else if (ph_q && scl_fall) begin
                        // ptr_q is already the incremented pointer here.
                        ph_d      = 1'b0;
                        state_d   = RDATA;
                        bit_cnt_d = 3'd0;
                        sda_out_d = rd_byte[7];
                        shift_d   = {rd_byte[6:0], 1'b0};
                    end
                end

                default: begin
                    state_d   = IDLE;
                    sda_out_d = 1'b1;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ph_q        <= 1'b0;
            sda_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ph_q        <= ph_d;
            sda_out_q   <= sda_out_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign SDA_out     = sda_out_q;
    assign busy        = busy_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign dbg_state_o = state_q;

endmodule
